alu_seq: RTL

Parametrised, handshaked successor to the combinational 32-bit ALU. It accepts one operation per transfer on a valid/ready input port and holds the registered result and N/Z/C flags on a valid/ready output port. A persistent carry/borrow flag chains multi-word ADD/SUB, and a multi-cycle iterative multiply is added. It sits between the control unit's operand/opcode issue stage and the register-file writeback.

---
 rtl/alu_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a persistent carry flag for multi-word
// ADD/SUB chains and an iterative radix-2 shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             err
);

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_MUL = 6'b010010;
  localparam logic [5:0] OP_CLC = 6'b010011;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LE  = 6'b100010;
  localparam logic [5:0] OP_GT  = 6'b100011;
  localparam logic [5:0] OP_LLS = 6'b110000;
  localparam logic [5:0] OP_LRS = 6'b110001;
  localparam logic [5:0] OP_ARS = 6'b110010;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state, state_next;
  logic               cf;
  logic               accept, mul_done;
  logic [2*WIDTH-1:0] acc, mcand, acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  // Single-cycle datapath signals
  logic [WIDTH:0]     add_full, sub_full;
  logic               shift_big;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   op_res;
  logic               op_c, op_err, cf_load, cf_new;

  // New work is taken only in IDLE and only if the output slot is free or draining
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_done = (state == S_MUL) && (cnt == CNT_LAST);

  // Carry/borrow live in the extra top bit of a WIDTH+1 wide add/subtract
  assign add_full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cf};
  assign sub_full  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cf};
  assign shift_big = |b[WIDTH-1:SHW];
  assign sh        = b[SHW-1:0];

  // One multiplier bit per cycle: add the shifted multiplicand when the LSB is set
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  // Single-cycle result, flags and carry update selected by opcode
  always_comb begin
    op_res  = '0;
    op_c    = 1'b0;
    op_err  = 1'b0;
    cf_load = 1'b0;
    cf_new  = 1'b0;
    case (op_code)
      OP_ADD: begin
        op_res  = add_full[WIDTH-1:0];
        op_c    = add_full[WIDTH];
        cf_load = 1'b1;
        cf_new  = add_full[WIDTH];
      end
      OP_SUB: begin
        op_res  = sub_full[WIDTH-1:0];
        op_c    = sub_full[WIDTH];
        cf_load = 1'b1;
        cf_new  = sub_full[WIDTH];
      end
      OP_MUL: op_res = '0;
      OP_CLC: cf_load = 1'b1;
      OP_EQ:  op_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_NE:  op_res = {{(WIDTH-1){1'b0}}, (a != b)};
      OP_LE:  op_res = {{(WIDTH-1){1'b0}}, (a <= b)};
      OP_GT:  op_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_LLS: op_res = shift_big ? '0 : (a << sh);
      OP_LRS: op_res = shift_big ? '0 : (a >> sh);
      OP_ARS: op_res = shift_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh);
      default: op_err = 1'b1;
    endcase
  end

  // Next-state logic: MUL is the only op that leaves IDLE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && (op_code == OP_MUL)) state_next = S_MUL;
      S_MUL:   if (cnt == CNT_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Multiplier operand capture and iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept && (op_code == OP_MUL)) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Output register and carry flag; a new load overrides a same-cycle drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      err       <= 1'b0;
      cf        <= 1'b0;
    end else if (accept && (op_code != OP_MUL)) begin
      out_valid <= 1'b1;
      result    <= op_res;
      flag_z    <= (op_res == '0);
      flag_n    <= op_res[WIDTH-1];
      flag_c    <= op_c;
      err       <= op_err;
      if (cf_load) cf <= cf_new;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= acc_sum[WIDTH-1:0];
      flag_z    <= (acc_sum[WIDTH-1:0] == '0);
      flag_n    <= acc_sum[WIDTH-1];
      flag_c    <= |acc_sum[2*WIDTH-1:WIDTH];
      err       <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
